// File: rtl/program_word_loader_if.sv
// Instruction-field handshake and program-memory write port shared by the
// boot/test sequencer (master) and the program word loader (slave).
interface program_word_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [5:0]        in_opc;
  logic [1:0]        in_rsel;
  logic [3:0]        in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output in_valid, in_fmt, in_opc, in_rsel, in_imm, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_fmt, in_opc, in_rsel, in_imm, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_word_loader.sv
// Encodes symbolic instruction fields into 8-bit ISA words and writes them to
// program memory from address 0. Optional read-back check: LOADER_VERIFY_EN.
module program_word_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  program_word_loader_if.slave    bus,
  output logic [ADDR_W:0]         count,
  output logic                    done,
  output logic                    err,
  output logic [2:0]              err_code
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [7:0]        HALT_WORD = 8'hFF;

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_FAULT, S_VERIFY} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_FAULT} state_t;
`endif

  state_t     state;
  logic [7:0] word_c;
  logic       opc_ok_c;
  logic       imm_ok_c;
  logic       halt_c;
  logic       accept_c;

`ifdef LOADER_VERIFY_EN
  logic       vphase;
  logic       halt_pend;
`else
  logic [ADDR_W-1:0] wr_addr_c;
  // address the next accepted word lands on, accounting for a write in flight
  assign wr_addr_c = bus.mem_addr + ADDR_W'(bus.mem_we);
`endif

  assign accept_c = bus.in_valid && bus.in_ready;
  assign halt_c   = (bus.in_fmt == 2'd3);

  // Field encoding and per-format opcode/immediate legality
  always_comb begin
    word_c   = 8'h00;
    opc_ok_c = 1'b0;
    imm_ok_c = 1'b1;
    case (bus.in_fmt)
      2'd0: begin
        word_c   = {bus.in_opc[2:0], bus.in_imm[2:0], bus.in_rsel};
        opc_ok_c = bus.in_opc[2:0] inside {3'b100, 3'b101, 3'b000, 3'b001};
        imm_ok_c = !bus.in_imm[3];
      end
      2'd1: begin
        word_c   = {bus.in_opc[3:0], bus.in_imm};
        opc_ok_c = bus.in_opc[3:0] inside {4'b0100, 4'b0101, 4'b0111};
      end
      2'd2: begin
        word_c   = {bus.in_opc, bus.in_rsel};
        opc_ok_c = bus.in_opc inside {6'b011000, 6'b110000, 6'b110001, 6'b110010};
      end
      default: begin
        word_c   = HALT_WORD;
        opc_ok_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 8'h00;
      count         <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= 3'd0;
`ifdef LOADER_VERIFY_EN
      vphase        <= 1'b0;
      halt_pend     <= 1'b0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
`ifndef LOADER_VERIFY_EN
      // bookkeeping for the word strobed this cycle; the address never wraps
      if (bus.mem_we) begin
        count <= count + (ADDR_W+1)'(1);
        if (bus.mem_addr != ADDR_LAST) bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
      end
`endif
      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            state        <= S_LOAD;
            bus.in_ready <= 1'b1;
            bus.mem_addr <= '0;
            count        <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= 3'd0;
          end
        end
        S_LOAD: begin
          if (accept_c) begin
            if (!opc_ok_c) begin
              state        <= S_FAULT;
              bus.in_ready <= 1'b0;
              err          <= 1'b1;
              err_code     <= 3'd1;
            end else if (!imm_ok_c) begin
              state        <= S_FAULT;
              bus.in_ready <= 1'b0;
              err          <= 1'b1;
              err_code     <= 3'd2;
            end else begin
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= word_c;
`ifdef LOADER_VERIFY_EN
              state        <= S_VERIFY;
              bus.in_ready <= 1'b0;
              vphase       <= 1'b0;
              halt_pend    <= halt_c;
`else
              if (halt_c) begin
                state        <= S_DONE;
                bus.in_ready <= 1'b0;
                done         <= 1'b1;
              end else if (wr_addr_c == ADDR_LAST) begin
                state        <= S_FAULT;
                bus.in_ready <= 1'b0;
                err          <= 1'b1;
                err_code     <= 3'd3;
              end
`endif
            end
          end
        end
`ifdef LOADER_VERIFY_EN
        // read data for the held address arrives on the second cycle
        S_VERIFY: begin
          vphase <= 1'b1;
          if (vphase) begin
            if (bus.mem_rdata != bus.mem_wdata) begin
              state    <= S_FAULT;
              err      <= 1'b1;
              err_code <= 3'd4;
            end else begin
              count <= count + (ADDR_W+1)'(1);
              if (bus.mem_addr != ADDR_LAST) bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
              if (halt_pend) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else if (bus.mem_addr == ADDR_LAST) begin
                state    <= S_FAULT;
                err      <= 1'b1;
                err_code <= 3'd3;
              end else begin
                state        <= S_LOAD;
                bus.in_ready <= 1'b1;
              end
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
      // abort overrides everything, including a strobe scheduled for next cycle
      if (abort) begin
        state        <= S_IDLE;
        bus.in_ready <= 1'b0;
        bus.mem_we   <= 1'b0;
        done         <= 1'b0;
        err          <= 1'b0;
        err_code     <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_program_word_loader.sv
// Directed scoreboard bench for program_word_loader (default build, plus the
// LOADER_VERIFY_EN read-back fault when that macro is defined).
module tb_program_word_loader;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start0, start1, abort, valid0, valid1;
  logic [1:0] fmt;
  logic [5:0] opc;
  logic [1:0] rsel;
  logic [3:0] imm;
  logic [7:0] rdata0;

  logic [8:0] count0;
  logic [2:0] count1;
  logic       done0, err0, done1, err1;
  logic [2:0] err_code0, err_code1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       sel;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t       q[$];
  logic [7:0] nxt_addr [2];

  program_word_loader_if #(.ADDR_W(8)) b0();
  program_word_loader_if #(.ADDR_W(2)) b1();

  assign b0.in_valid  = valid0;
  assign b0.in_fmt    = fmt;
  assign b0.in_opc    = opc;
  assign b0.in_rsel   = rsel;
  assign b0.in_imm    = imm;
  assign b0.mem_rdata = rdata0;
  assign b1.in_valid  = valid1;
  assign b1.in_fmt    = fmt;
  assign b1.in_opc    = opc;
  assign b1.in_rsel   = rsel;
  assign b1.in_imm    = imm;
  assign b1.mem_rdata = 8'h00;

  program_word_loader #(.ADDR_W(8)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort), .bus(b0),
    .count(count0), .done(done0), .err(err0), .err_code(err_code0)
  );

  program_word_loader #(.ADDR_W(2)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort), .bus(b1),
    .count(count1), .done(done1), .err(err1), .err_code(err_code1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b1.in_ready : b0.in_ready;
  endfunction

  function automatic logic we(input bit sel);
    return sel ? b1.mem_we : b0.mem_we;
  endfunction

  // scoreboard side: every strobe must match the oldest expected write
  task automatic mon(input bit sel, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    checks++;
    assert (q.size() != 0) else begin
      errors++;
      $error("FAIL unexpected_write sel=%0d observed addr=%0h data=%0h expected no write", sel, a, d);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("wr_sel",  32'(sel), 32'(e.sel));
      chk("wr_addr", 32'(a),   32'(e.addr));
      chk("wr_data", 32'(d),   32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (b0.mem_we) mon(1'b0, b0.mem_addr, b0.mem_wdata);
    if (b1.mem_we) mon(1'b1, 8'(b1.mem_addr), b1.mem_wdata);
  end

  task automatic pulse_start(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    nxt_addr[int'(sel)] = 8'h00;
  endtask

  // drive one field set for a single cycle; expects the loader ready now
  task automatic send(input bit sel, input logic [1:0] f, input logic [5:0] o,
                      input logic [1:0] r, input logic [3:0] i,
                      input logic [7:0] w, input bit legal);
    exp_t e;
    fmt = f; opc = o; rsel = r; imm = i;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    chk("ready_at_drive", 32'(rdy(sel)), 32'd1);
    if (legal) begin
      e.sel  = sel;
      e.addr = nxt_addr[int'(sel)];
      e.data = w;
      q.push_back(e);
      nxt_addr[int'(sel)] = nxt_addr[int'(sel)] + 8'd1;
    end
    @(negedge clk);
    chk("strobe_after_accept", 32'(we(sel)), 32'(legal));
  endtask

  task automatic idle();
    valid0 = 1'b0;
    valid1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0; fmt = 2'd0; opc = 6'd0; rsel = 2'd0; imm = 4'd0;
    rdata0 = 8'h00;
    nxt_addr[0] = 8'h00;
    nxt_addr[1] = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_ready",    32'(b0.in_ready),  32'd0);
    chk("rst_we",       32'(b0.mem_we),    32'd0);
    chk("rst_addr",     32'(b0.mem_addr),  32'd0);
    chk("rst_wdata",    32'(b0.mem_wdata), 32'h00);
    chk("rst_count",    32'(count0),       32'd0);
    chk("rst_done",     32'(done0),        32'd0);
    chk("rst_err",      32'(err0),         32'd0);
    chk("rst_err_code", 32'(err_code0),    32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_not_ready", 32'(b0.in_ready), 32'd0);

`ifdef LOADER_VERIFY_EN
    // read-back returns 0x00 for a written 0x96
    pulse_start(1'b0);
    send(1'b0, 2'd0, 6'b000100, 2'd2, 4'd5, 8'h96, 1'b1);
    idle();
    repeat (2) @(negedge clk);
    chk("vfy_err",      32'(err0),      32'd1);
    chk("vfy_err_code", 32'(err_code0), 32'd4);
    chk("vfy_count",    32'(count0),    32'd0);
`else
    // single A word
    pulse_start(1'b0);
    chk("load_ready", 32'(b0.in_ready), 32'd1);
    send(1'b0, 2'd0, 6'b000100, 2'd2, 4'd5, 8'h96, 1'b1);
    idle();
    chk("t1_count", 32'(count0),     32'd1);
    chk("t1_addr",  32'(b0.mem_addr), 32'd1);

    // back-to-back B, C, HALT
    send(1'b0, 2'd1, 6'b000101, 2'd0, 4'hA, 8'h5A, 1'b1);
    send(1'b0, 2'd2, 6'b110001, 2'd3, 4'h0, 8'hC7, 1'b1);
    send(1'b0, 2'd3, 6'b101010, 2'd1, 4'h3, 8'hFF, 1'b1);
    idle();
    chk("t2_done",  32'(done0),       32'd1);
    chk("t2_count", 32'(count0),      32'd4);
    chk("t2_ready", 32'(b0.in_ready), 32'd0);
    chk("t2_err",   32'(err0),        32'd0);

    // illegal opcode after one good word
    pulse_start(1'b0);
    chk("t3_done_clr",  32'(done0),        32'd0);
    chk("t3_count_clr", 32'(count0),       32'd0);
    send(1'b0, 2'd0, 6'b000100, 2'd2, 4'd5, 8'h96, 1'b1);
    idle();
    send(1'b0, 2'd0, 6'b000010, 2'd0, 4'd0, 8'h00, 1'b0);
    idle();
    chk("t3_err",      32'(err0),        32'd1);
    chk("t3_err_code", 32'(err_code0),   32'd1);
    chk("t3_count",    32'(count0),      32'd1);
    chk("t3_ready",    32'(b0.in_ready), 32'd0);
    pulse_start(1'b0);
    chk("t3_err_clr",  32'(err0),        32'd0);
    chk("t3_code_clr", 32'(err_code0),   32'd0);
    chk("t3_addr_clr", 32'(b0.mem_addr), 32'd0);

    // A immediate out of range, then A 001 imm 7
    send(1'b0, 2'd0, 6'b000101, 2'd1, 4'd9, 8'h00, 1'b0);
    idle();
    chk("t4_err_code", 32'(err_code0), 32'd2);
    chk("t4_count",    32'(count0),    32'd0);
    pulse_start(1'b0);
    send(1'b0, 2'd0, 6'b000001, 2'd0, 4'd7, 8'h3C, 1'b1);
    idle();
    chk("t4_count2", 32'(count0), 32'd1);

    // abort in the accept cycle drops the pending write
    fmt = 2'd0; opc = 6'b000100; rsel = 2'd2; imm = 4'd5;
    valid0 = 1'b1;
    abort  = 1'b1;
    chk("ab_ready_at_drive", 32'(b0.in_ready), 32'd1);
    @(negedge clk);
    valid0 = 1'b0;
    abort  = 1'b0;
    chk("ab_no_we",  32'(b0.mem_we),   32'd0);
    chk("ab_ready",  32'(b0.in_ready), 32'd0);
    chk("ab_count",  32'(count0),      32'd1);
    @(negedge clk);
    chk("ab_idle",   32'(b0.in_ready), 32'd0);
    pulse_start(1'b0);
    chk("ab_restart", 32'(b0.in_ready), 32'd1);

    // reset in the accept cycle: no partial write
    fmt = 2'd1; opc = 6'b000111; rsel = 2'd0; imm = 4'h1;
    valid0  = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rm_no_we", 32'(b0.mem_we),   32'd0);
    chk("rm_ready", 32'(b0.in_ready), 32'd0);
    valid0  = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // ADDR_W=2 overflow after four words
    pulse_start(1'b1);
    send(1'b1, 2'd0, 6'b000100, 2'd2, 4'd5, 8'h96, 1'b1);
    send(1'b1, 2'd0, 6'b000001, 2'd0, 4'd7, 8'h3C, 1'b1);
    send(1'b1, 2'd2, 6'b110001, 2'd3, 4'd0, 8'hC7, 1'b1);
    send(1'b1, 2'd1, 6'b000101, 2'd0, 4'hA, 8'h5A, 1'b1);
    fmt = 2'd2; opc = 6'b011000; rsel = 2'd1; imm = 4'd0;
    chk("ov_fifth_ready", 32'(b1.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    idle();
    chk("ov_err",      32'(err1),        32'd1);
    chk("ov_err_code", 32'(err_code1),   32'd3);
    chk("ov_count",    32'(count1),      32'd4);
    chk("ov_addr",     32'(b1.mem_addr), 32'd3);
    chk("ov_done",     32'(done1),       32'd0);
`endif

    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
